// File: rtl/spi_rx_pkg.sv
// Shared constants for the Pico serial audio receiver.
// State encodings are plain localparams so every synthesis flow reads them.
package spi_rx_pkg;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RECEIVING = 2'd1;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_CHANNELS = 2;

    function automatic int ch_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO only lands when a pop frees a slot.
// The head reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/spi_audio_rx_fifo.sv
// Pico->FPGA serial audio receiver: framed SCLK/MOSI words tagged with a
// round-robin channel index and queued in an output FIFO.
module spi_audio_rx_fifo
    import spi_rx_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int CHANNELS       = DEF_CHANNELS,
    parameter int FIFO_DEPTH     = 8,
    parameter int SAMPLE_FALLING = 0,
    parameter int MSB_FIRST      = 1,
    localparam int CH_W  = ch_width(CHANNELS),
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk_25mhz,
    input  logic              reset_n,
    input  logic              com_sclk_in,
    input  logic              com_mosi_in,
    input  logic              com_active,
    input  logic              rx_ready,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] rx_data,
    output logic [CH_W-1:0]   rx_channel,
    output logic              rx_valid,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow,
    output logic              frame_err,
    output logic              teste_mosi
);

    localparam int BC_W = $clog2(DATA_W);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_W - 1);
    localparam logic [CH_W-1:0] CH_LAST  = CH_W'(CHANNELS - 1);

    logic [2:0]        sclk_q;
    logic [1:0]        mosi_q;
    logic [1:0]        act_q;
    logic [1:0]        state;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_nxt;
    logic [BC_W-1:0]   bit_cnt;
    logic [CH_W-1:0]   ch_cnt;
    logic              active;
    logic              bit_in;
    logic              sample;
    logic              push;
    logic              drop;
    logic              full;
    logic              empty;

    always_ff @(posedge clk_25mhz) begin
        if (!reset_n) begin
            sclk_q <= '0;
            mosi_q <= '0;
            act_q  <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], com_sclk_in};
            mosi_q <= {mosi_q[0], com_mosi_in};
            act_q  <= {act_q[0], com_active};
        end
    end

    // MOSI comes from the same stage as the new SCLK level so both line up
    assign active = act_q[1];
    assign bit_in = mosi_q[1];
    assign sample = (SAMPLE_FALLING != 0) ? (~sclk_q[1] & sclk_q[2])
                                          : (sclk_q[1] & ~sclk_q[2]);

    assign shift_nxt = (MSB_FIRST != 0) ? {shift_q[DATA_W-2:0], bit_in}
                                        : {bit_in, shift_q[DATA_W-1:1]};

    assign push = (state == RECEIVING) & active & sample
                & (bit_cnt == BIT_LAST);
    assign drop = push & full & ~rx_ready;

    always_ff @(posedge clk_25mhz) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift_q    <= '0;
            bit_cnt    <= '0;
            ch_cnt     <= '0;
            frame_err  <= 1'b0;
            teste_mosi <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overflow  <= drop | (overflow & ~ovf_clr);
            if (sample) teste_mosi <= bit_in;
            case (state)
                IDLE: begin
                    if (active) begin
                        state   <= RECEIVING;
                        shift_q <= '0;
                        bit_cnt <= '0;
                        ch_cnt  <= '0;
                    end
                end
                RECEIVING: begin
                    // frame end beats a coincident sample event
                    if (!active) begin
                        state     <= IDLE;
                        frame_err <= (bit_cnt != '0);
                        bit_cnt   <= '0;
                    end else if (sample) begin
                        shift_q <= shift_nxt;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            ch_cnt  <= (ch_cnt == CH_LAST) ? '0
                                     : ch_cnt + CH_W'(1);
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W + CH_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_25mhz),
        .reset_n (reset_n),
        .push    (push),
        .wr_data ({shift_nxt, ch_cnt}),
        .pop     (rx_ready),
        .rd_data ({rx_data, rx_channel}),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    assign rx_valid = ~empty;

endmodule

// File: tb/tb_spi_audio_rx_fifo.sv
// Bench for spi_audio_rx_fifo: an MSB-first rising-edge instance and an
// LSB-first falling-edge 3-channel instance share one serial stimulus.
module tb_spi_audio_rx_fifo;

    localparam int CH_A  = 2;
    localparam int CH_B  = 3;
    localparam int DEP_A = 8;
    localparam int DEP_B = 4;

    typedef struct {
        logic [15:0] d;
        int          ch;
    } exp_t;

    typedef struct {
        logic [15:0] tx;
        logic [15:0] da;
        int          ca;
        logic [15:0] db;
        int          cb;
    } vec_t;

    logic        clk_25mhz = 1'b0;
    logic        reset_n;
    logic        sclk;
    logic        mosi;
    logic        act;
    logic        rx_ready;
    logic        ovf_clr;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic        ch_a;
    logic [1:0]  ch_b;
    logic        valid_a;
    logic        valid_b;
    logic [3:0]  lvl_a;
    logic [2:0]  lvl_b;
    logic        ovf_a;
    logic        ovf_b;
    logic        ferr_a;
    logic        ferr_b;
    logic        tm_a;
    logic        tm_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   widx;
    bit   eovf_a;
    bit   eovf_b;
    bit   rand_ready;
    int   n_pass;
    int   n_checks;

    always #20 clk_25mhz = ~clk_25mhz;

    spi_audio_rx_fifo #(
        .DATA_W(16), .CHANNELS(CH_A), .FIFO_DEPTH(DEP_A),
        .SAMPLE_FALLING(0), .MSB_FIRST(1)
    ) dut_a (
        .clk_25mhz(clk_25mhz), .reset_n(reset_n),
        .com_sclk_in(sclk), .com_mosi_in(mosi), .com_active(act),
        .rx_ready(rx_ready), .ovf_clr(ovf_clr),
        .rx_data(data_a), .rx_channel(ch_a), .rx_valid(valid_a),
        .fifo_level(lvl_a), .overflow(ovf_a), .frame_err(ferr_a),
        .teste_mosi(tm_a)
    );

    spi_audio_rx_fifo #(
        .DATA_W(16), .CHANNELS(CH_B), .FIFO_DEPTH(DEP_B),
        .SAMPLE_FALLING(1), .MSB_FIRST(0)
    ) dut_b (
        .clk_25mhz(clk_25mhz), .reset_n(reset_n),
        .com_sclk_in(sclk), .com_mosi_in(mosi), .com_active(act),
        .rx_ready(rx_ready), .ovf_clr(ovf_clr),
        .rx_data(data_b), .rx_channel(ch_b), .rx_valid(valid_b),
        .fifo_level(lvl_b), .overflow(ovf_b), .frame_err(ferr_b),
        .teste_mosi(tm_b)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, got, want);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk_25mhz);
            if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // LSB-first receiver sees the transmitted MSB-first stream reversed
    function automatic logic [15:0] bitrev(input logic [15:0] w);
        logic [15:0] r = '0;
        for (int i = 0; i < 16; i++) r[15-i] = w[i];
        return r;
    endfunction

    function automatic exp_t model_a(input logic [15:0] w);
        return '{d: w, ch: widx % CH_A};
    endfunction

    function automatic exp_t model_b(input logic [15:0] w);
        return '{d: bitrev(w), ch: widx % CH_B};
    endfunction

    task automatic push_a(input exp_t e, input bit pop_now);
        if (q_a.size() < DEP_A || pop_now) q_a.push_back(e);
        else eovf_a = 1'b1;
    endtask

    task automatic push_b(input exp_t e);
        if (q_b.size() < DEP_B) q_b.push_back(e);
        else eovf_b = 1'b1;
    endtask

    task automatic start_frame();
        act  = 1'b1;
        widx = 0;
        tick(4);
    endtask

    task automatic end_frame();
        act = 1'b0;
        tick(4);
    endtask

    task automatic send_bits(input int n, input logic b);
        for (int i = 0; i < n; i++) begin
            mosi = b;
            tick(2);
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
            tick(4);
        end
    endtask

    task automatic send_word(input logic [15:0] w, input exp_t ea,
                             input exp_t eb, input bit pulse, input bit lat);
        for (int i = 15; i >= 0; i--) begin
            mosi = w[i];
            tick(2);
            sclk = 1'b1;
            if (i == 0) push_a(ea, pulse);
            tick(2);
            if (i == 0 && lat) begin
                #2 check("lat_before", 32'(valid_a), 0);
            end
            if (i == 0 && pulse) rx_ready = 1'b1;
            tick(1);
            if (i == 0 && pulse) rx_ready = 1'b0;
            if (i == 0 && lat) begin
                #2 check("lat_after", 32'(valid_a), 1);
            end
            tick(1);
            sclk = 1'b0;
            if (i == 0) push_b(eb);
            tick(4);
        end
        widx++;
    endtask

    task automatic send_model(input logic [15:0] w, input bit pulse);
        send_word(w, model_a(w), model_b(w), pulse, 1'b0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_25mhz);
            #2;
            if (reset_n && valid_a && rx_ready) begin
                if (q_a.size() == 0) check("a_extra_word", 32'(data_a), 0);
                else begin
                    e = q_a.pop_front();
                    check("a_data", 32'(data_a), 32'(e.d));
                    check("a_chan", 32'(ch_a), 32'(e.ch));
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_25mhz);
            #2;
            if (reset_n && valid_b && rx_ready) begin
                if (q_b.size() == 0) check("b_extra_word", 32'(data_b), 0);
                else begin
                    e = q_b.pop_front();
                    check("b_data", 32'(data_b), 32'(e.d));
                    check("b_chan", 32'(ch_b), 32'(e.ch));
                end
            end
        end
    end

    initial begin
        vec_t tbl[5];
        int   cnt_a;
        int   cnt_b;
        int   nw;
        logic [15:0] w;

        tbl[0] = '{16'hA5C3, 16'hA5C3, 0, 16'hC3A5, 0};
        tbl[1] = '{16'h1234, 16'h1234, 1, 16'h2C48, 1};
        tbl[2] = '{16'h8000, 16'h8000, 0, 16'h0001, 2};
        tbl[3] = '{16'hBEEF, 16'hBEEF, 1, 16'hF77D, 0};
        tbl[4] = '{16'h00FF, 16'h00FF, 0, 16'hFF00, 1};

        n_pass = 0; n_checks = 0; widx = 0;
        eovf_a = 0; eovf_b = 0; rand_ready = 0;
        reset_n = 1'b0; sclk = 1'b0; mosi = 1'b0; act = 1'b0;
        rx_ready = 1'b0; ovf_clr = 1'b0;
        tick(3);
        #2;
        check("rst_valid_a", 32'(valid_a), 0);
        check("rst_level_a", 32'(lvl_a), 0);
        check("rst_data_a",  32'(data_a), 0);
        check("rst_ovf_a",   32'(ovf_a), 0);
        check("rst_ferr_a",  32'(ferr_a), 0);
        check("rst_tm_a",    32'(tm_a), 0);
        check("rst_valid_b", 32'(valid_b), 0);
        check("rst_level_b", 32'(lvl_b), 0);
        reset_n = 1'b1;
        tick(2);

        rx_ready = 1'b1;
        start_frame();
        for (int i = 0; i < 5; i++)
            send_word(tbl[i].tx, '{d: tbl[i].da, ch: tbl[i].ca},
                      '{d: tbl[i].db, ch: tbl[i].cb}, 1'b0, i == 0);
        end_frame();
        tick(10);
        check("tbl_drain_a", q_a.size(), 0);
        check("tbl_drain_b", q_b.size(), 0);

        start_frame();
        send_bits(5, 1'b1);
        act = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            #2;
            cnt_a += int'(ferr_a);
            cnt_b += int'(ferr_b);
        end
        check("ferr_pulse_a", cnt_a, 1);
        check("ferr_pulse_b", cnt_b, 1);
        check("ferr_level_a", 32'(lvl_a), 0);
        start_frame();
        send_word(16'hBEEF, '{d: 16'hBEEF, ch: 0},
                  '{d: 16'hF77D, ch: 0}, 1'b0, 1'b0);
        end_frame();
        tick(10);
        check("beef_drain_a", q_a.size(), 0);

        rx_ready = 1'b0;
        start_frame();
        for (int k = 0; k < 9; k++) send_model(16'($urandom), 1'b0);
        #2;
        check("full_level_a", 32'(lvl_a), q_a.size());
        check("full_ovf_a",   32'(ovf_a), 32'(eovf_a));
        check("full_level_b", 32'(lvl_b), q_b.size());
        check("full_ovf_b",   32'(ovf_b), 32'(eovf_b));
        check("head_hold_a",  32'(data_a), 32'(q_a[0].d));
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        eovf_a = 0; eovf_b = 0;
        #2 check("ovf_clr_a", 32'(ovf_a), 0);
        send_model(16'($urandom), 1'b1);
        #2;
        check("pushpop_level_a", 32'(lvl_a), 8);
        check("pushpop_ovf_a",   32'(ovf_a), 0);
        check("pushpop_ovf_b",   32'(ovf_b), 32'(eovf_b));
        rx_ready = 1'b1;
        tick(20);
        end_frame();
        check("ovf_drain_a", q_a.size(), 0);
        check("ovf_drain_b", q_b.size(), 0);

        rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            start_frame();
            nw = $urandom_range(1, 4);
            for (int k = 0; k < nw; k++) begin
                w = 16'($urandom);
                send_model(w, 1'b0);
            end
            end_frame();
            tick(10);
        end
        rand_ready = 1'b0;
        rx_ready = 1'b1;
        tick(20);
        check("rand_drain_a", q_a.size(), 0);
        check("rand_drain_b", q_b.size(), 0);
        check("rand_ovf_a", 32'(ovf_a), 32'(eovf_a));

        rx_ready = 1'b0;
        start_frame();
        for (int k = 0; k < 3; k++) send_model(16'($urandom), 1'b0);
        send_bits(5, 1'b1);
        #2;
        check("pre_rst_level_a", 32'(lvl_a), 3);
        check("pre_rst_tm_a", 32'(tm_a), 1);
        reset_n = 1'b0;
        act = 1'b0;
        tick(1);
        #2;
        check("mid_rst_valid_a", 32'(valid_a), 0);
        check("mid_rst_level_a", 32'(lvl_a), 0);
        check("mid_rst_ovf_a",   32'(ovf_a), 0);
        check("mid_rst_ferr_a",  32'(ferr_a), 0);
        check("mid_rst_tm_a",    32'(tm_a), 0);
        check("mid_rst_level_b", 32'(lvl_b), 0);
        q_a.delete();
        q_b.delete();
        reset_n = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            #2 cnt_a += int'(ferr_a) + int'(ferr_b);
        end
        check("post_rst_ferr", cnt_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
